// File: rtl/frame_sync_defs.sv
// Shared definitions for the frame synchroniser: FSM state encodings and default sync pattern.
package frame_sync_defs;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    CONFIRM  = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } sync_state_e;

  localparam int unsigned DEF_SYNC_LEN = 4;
  localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC_WORD = 4'b1001;

endpackage

// File: rtl/sync_window_match.sv
// Sliding sync-word matcher over an LSB-first serial stream; sync_hit is combinational.
module sync_window_match
  import frame_sync_defs::*;
#(
  parameter int unsigned         SYNC_LEN  = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DEF_SYNC_WORD)
) (
  input  logic clk,
  input  logic Reset,
  input  logic data_in,
  input  logic data_valid,
  output logic sync_hit
);

  logic [SYNC_LEN-1:0] window;
  logic [SYNC_LEN-1:0] window_next;

  // Newest bit enters at the MSB so window[0] holds the first-received bit of the pattern.
  assign window_next = {data_in, window[SYNC_LEN-1:1]};
  assign sync_hit    = data_valid && (window_next == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (Reset) begin
      window <= ~SYNC_WORD;
    end else if (data_valid) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/frame_sync_controller.sv
// Serial frame-sync controller: hunt, confirm, lock with flywheel, parallel payload delivery.
// Optional statistics outputs (frame_count, loss_count) are enabled by defining FRAME_SYNC_STATS_EN.
module frame_sync_controller
  import frame_sync_defs::*;
#(
  parameter int unsigned         SYNC_LEN    = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(DEF_SYNC_WORD),
  parameter int unsigned         PAYLOAD_LEN = 8,
  parameter int unsigned         CONFIRM_CNT = 2,
  parameter int unsigned         LOSS_CNT    = 2
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   data_in,
  input  logic                   data_valid,
  output logic [PAYLOAD_LEN-1:0] payload,
  output logic                   payload_valid,
  output logic                   locked,
  output logic [1:0]             sync_state,
  output logic                   sync_error
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [7:0]             loss_count
`endif
);

  localparam int unsigned FRAME_LEN = PAYLOAD_LEN + SYNC_LEN;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [3:0] CONFIRM_TGT = 4'(CONFIRM_CNT);
  localparam logic [3:0] LOSS_TGT    = 4'(LOSS_CNT);

  sync_state_e state;
  sync_state_e state_next;

  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_next;
  logic [3:0]           hit_cnt;
  logic [3:0]           hit_cnt_next;
  logic [3:0]           miss_cnt;
  logic [3:0]           miss_cnt_next;
  logic [PAYLOAD_LEN-1:0] pay_shift;
  logic [PAYLOAD_LEN:0]   pay_cat;
  logic sync_hit;
  logic boundary;
  logic in_lock;
  logic valid_next;
  logic error_next;

  sync_window_match #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_match (
    .clk        (clk),
    .Reset      (Reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sync_hit   (sync_hit)
  );

  assign boundary   = data_valid && (bit_cnt == LAST_BIT);
  assign in_lock    = (state == LOCKED) || (state == FLYWHEEL);
  assign pay_cat    = {data_in, pay_shift};
  assign sync_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and frame counters; sync is only judged at frame boundaries once out of HUNT.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    hit_cnt_next  = hit_cnt;
    miss_cnt_next = miss_cnt;
    if (data_valid) begin
      bit_cnt_next = boundary ? '0 : bit_cnt + CNT_W'(1);
    end
    case (state)
      HUNT: begin
        bit_cnt_next = '0;
        hit_cnt_next = '0;
        if (sync_hit) state_next = CONFIRM;
      end
      CONFIRM: begin
        if (boundary) begin
          if (!sync_hit) begin
            state_next   = HUNT;
            hit_cnt_next = '0;
          end else if (hit_cnt + 4'd1 == CONFIRM_TGT) begin
            state_next   = LOCKED;
            hit_cnt_next = '0;
          end else begin
            hit_cnt_next = hit_cnt + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (boundary && !sync_hit) begin
          if (LOSS_TGT == 4'd1) begin
            state_next    = HUNT;
            miss_cnt_next = '0;
          end else begin
            state_next    = FLYWHEEL;
            miss_cnt_next = 4'd1;
          end
        end
      end
      FLYWHEEL: begin
        if (boundary) begin
          if (sync_hit) begin
            state_next    = LOCKED;
            miss_cnt_next = '0;
          end else if (miss_cnt + 4'd1 == LOSS_TGT) begin
            state_next    = HUNT;
            miss_cnt_next = '0;
          end else begin
            miss_cnt_next = miss_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next   = HUNT;
        bit_cnt_next = '0;
      end
    endcase
  end

  // Output pulses for the coming edge
  always_comb begin
    valid_next = 1'b0;
    error_next = 1'b0;
    if (data_valid && in_lock) begin
      valid_next = (bit_cnt == LAST_PAY);
      error_next = boundary && !sync_hit;
    end
  end

  // Counters, payload shifter and registered outputs
  always_ff @(posedge clk) begin
    if (Reset) begin
      bit_cnt       <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      pay_shift     <= '0;
      payload       <= '0;
      payload_valid <= 1'b0;
      sync_error    <= 1'b0;
      locked        <= 1'b0;
    end else begin
      bit_cnt       <= bit_cnt_next;
      hit_cnt       <= hit_cnt_next;
      miss_cnt      <= miss_cnt_next;
      payload_valid <= valid_next;
      sync_error    <= error_next;
      locked        <= (state_next == LOCKED) || (state_next == FLYWHEEL);
      if (data_valid && (bit_cnt <= LAST_PAY)) pay_shift <= pay_cat[PAYLOAD_LEN:1];
      if (valid_next) payload <= pay_cat[PAYLOAD_LEN:1];
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  // Saturating delivery and lock-loss statistics
  always_ff @(posedge clk) begin
    if (Reset) begin
      frame_count <= '0;
      loss_count  <= '0;
    end else begin
      if (valid_next && (frame_count != 16'hFFFF)) frame_count <= frame_count + 16'd1;
      if (in_lock && (state_next == HUNT) && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_sync_controller.sv
// Bench for frame_sync_controller: vector table, directed corner sequences and a random gapped stream
// checked against a bit-history reference model.
module tb_frame_sync_controller;

  localparam int unsigned SL = 4;
  localparam int unsigned PL = 8;
  localparam int unsigned FL = PL + SL;
  localparam int unsigned CC = 2;
  localparam int unsigned LC = 2;
  localparam logic [SL-1:0] SW  = 4'b1001;
  localparam logic [SL-1:0] BAD = 4'b1011;

  logic clk;
  logic Reset;
  logic data_in;
  logic data_valid;
  logic [PL-1:0] payload;
  logic payload_valid;
  logic locked;
  logic [1:0] sync_state;
  logic sync_error;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  loss_count;
`endif

  frame_sync_controller #(
    .SYNC_LEN    (SL),
    .SYNC_WORD   (SW),
    .PAYLOAD_LEN (PL),
    .CONFIRM_CNT (CC),
    .LOSS_CNT    (LC)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .payload       (payload),
    .payload_valid (payload_valid),
    .locked        (locked),
    .sync_state    (sync_state),
    .sync_error    (sync_error)
`ifdef FRAME_SYNC_STATS_EN
    ,
    .frame_count   (frame_count),
    .loss_count    (loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_seen  = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: keeps the raw received-bit history and judges sync/payload from it.
  int m_state, m_pos, m_hits, m_miss, m_frames, m_losses, m_pv_total;
  bit m_hist[$];
  logic [PL-1:0] m_pay;
  bit m_pv, m_err;

  function automatic void model_reset();
    m_state = 0; m_pos = 0; m_hits = 0; m_miss = 0;
    m_frames = 0; m_losses = 0; m_pay = '0; m_pv = 0; m_err = 0;
    m_hist.delete();
    for (int i = 0; i < SL; i++) m_hist.push_back(~SW[i]);
  endfunction

  function automatic bit model_match();
    int base = m_hist.size() - SL;
    for (int i = 0; i < SL; i++) if (m_hist[base + i] != SW[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_bit(input bit b);
    bit hit;
    m_pv = 0; m_err = 0;
    m_hist.push_back(b);
    if (m_hist.size() > 64) void'(m_hist.pop_front());
    hit = model_match();
    if (m_state == 0) begin
      if (hit) begin m_state = 1; m_hits = 0; m_pos = 0; end
      return;
    end
    if (m_state >= 2 && m_pos == PL - 1) begin
      m_pv = 1; m_pv_total++;
      for (int i = 0; i < PL; i++) m_pay[i] = m_hist[m_hist.size() - PL + i];
      if (m_frames < 65535) m_frames++;
    end
    if (m_pos == FL - 1) begin
      m_pos = 0;
      case (m_state)
        1: if (hit) begin
             m_hits++;
             if (m_hits == CC) begin m_state = 2; m_hits = 0; end
           end else begin m_state = 0; m_hits = 0; end
        2: if (!hit) begin
             m_err = 1;
             if (LC == 1) begin m_state = 0; if (m_losses < 255) m_losses++; end
             else begin m_state = 3; m_miss = 1; end
           end
        default: if (hit) begin m_state = 2; m_miss = 0; end
           else begin
             m_err = 1; m_miss++;
             if (m_miss == LC) begin m_state = 0; m_miss = 0; if (m_losses < 255) m_losses++; end
           end
      endcase
    end else begin
      m_pos++;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_state"},   sync_state,    m_state);
    check({tag, "_locked"},  locked,        (m_state >= 2));
    check({tag, "_pvalid"},  payload_valid, m_pv);
    check({tag, "_serr"},    sync_error,    m_err);
    check({tag, "_payload"}, payload,       m_pay);
`ifdef FRAME_SYNC_STATS_EN
    check({tag, "_frames"},  frame_count,   m_frames);
    check({tag, "_losses"},  loss_count,    m_losses);
`endif
  endtask

  task automatic step(input bit b, input bit v, input bit r, input string tag);
    @(negedge clk);
    Reset = r; data_in = b; data_valid = v;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (v) model_bit(b);
    else begin m_pv = 0; m_err = 0; end
    if (payload_valid) pv_seen++;
    if (sync_error) err_seen++;
    compare_all(tag);
  endtask

  task automatic send_word(input logic [31:0] w, input int n, input bit gaps, input string tag);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, tag);
      step(w[i], 1'b1, 1'b0, tag);
    end
  endtask

  typedef struct {
    bit rst; bit din; bit dv;
    logic [1:0] st; bit lk; bit pv; bit err; logic [PL-1:0] pay;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit rst, bit din, bit dv, logic [1:0] st, bit lk, bit pv,
                              bit err, logic [PL-1:0] pay);
    vec_t v;
    v.rst = rst; v.din = din; v.dv = dv; v.st = st; v.lk = lk; v.pv = pv; v.err = err; v.pay = pay;
    vecs.push_back(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PL-1:0] a5, c3;
    logic [31:0] w;
    a5 = 8'hA5; c3 = 8'h3C;
    Reset = 1'b1; data_in = 1'b0; data_valid = 1'b0;

    // Lock-up table: sync, A5 payloads, confirm over two more syncs, then delivery
    add(1, 0, 0, 2'd0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(0, SW[i], 1, (i == 3) ? 2'd1 : 2'd0, 0, 0, 0, 8'h00);
    add(0, 1, 0, 2'd1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      add(0, a5[i], 1, 2'd1, 0, 0, 0, 8'h00);
      if (i == 3) add(0, 1, 0, 2'd1, 0, 0, 0, 8'h00);
    end
    for (int i = 0; i < 4; i++) add(0, SW[i], 1, 2'd1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) add(0, a5[i], 1, 2'd1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(0, SW[i], 1, (i == 3) ? 2'd2 : 2'd1, (i == 3), 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) add(0, a5[i], 1, 2'd2, 1, (i == 7), 0, (i == 7) ? 8'hA5 : 8'h00);
    add(0, 0, 0, 2'd2, 1, 0, 0, 8'hA5);
    for (int i = 0; i < 4; i++) add(0, SW[i], 1, 2'd2, 1, 0, 0, 8'hA5);
    for (int i = 0; i < 8; i++) add(0, c3[i], 1, 2'd2, 1, (i == 7), 0, (i == 7) ? 8'h3C : 8'hA5);

    foreach (vecs[k]) begin
      @(negedge clk);
      Reset = vecs[k].rst; data_in = vecs[k].din; data_valid = vecs[k].dv;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_state", k),   sync_state,    vecs[k].st);
      check($sformatf("vec%0d_locked", k),  locked,        vecs[k].lk);
      check($sformatf("vec%0d_pvalid", k),  payload_valid, vecs[k].pv);
      check($sformatf("vec%0d_serr", k),    sync_error,    vecs[k].err);
      check($sformatf("vec%0d_payload", k), payload,       vecs[k].pay);
    end

    // Confirm failure: corrupted second sync drops back to HUNT
    step(0, 0, 1, "cf");
    pv_seen = 0;
    send_word(SW, 4, 0, "cf"); send_word(32'hA5, 8, 0, "cf"); send_word(BAD, 4, 0, "cf");
    check("cf_state_hunt", sync_state, 0);
    check("cf_unlocked", locked, 0);
    check("cf_no_payload", pv_seen, 0);

    // Flywheel: one bad sync while locked, then recovery
    step(0, 0, 1, "fw");
    repeat (2) begin send_word(SW, 4, 0, "fw"); send_word(32'hA5, 8, 0, "fw"); end
    send_word(SW, 4, 0, "fw");
    check("fw_locked_state", sync_state, 2);
    check("fw_locked_flag", locked, 1);
    send_word(32'hA5, 8, 0, "fw");
    pv_seen = 0; err_seen = 0;
    send_word(BAD, 4, 0, "fw");
    check("fw_state_fly", sync_state, 3);
    check("fw_locked_fly", locked, 1);
    check("fw_err_count", err_seen, 1);
    send_word(32'h3C, 8, 0, "fw");
    check("fw_payload_fly", payload, 8'h3C);
    send_word(SW, 4, 0, "fw");
    check("fw_state_relock", sync_state, 2);
    send_word(32'h5A, 8, 0, "fw");
    check("fw_pv_count", pv_seen, 2);
    check("fw_err_total", err_seen, 1);

    // Loss of lock: two consecutive bad syncs
    err_seen = 0;
    send_word(BAD, 4, 0, "loss");
    check("loss_state_fly", sync_state, 3);
    send_word(32'h0F, 8, 0, "loss");
    send_word(BAD, 4, 0, "loss");
    check("loss_state_hunt", sync_state, 0);
    check("loss_unlocked", locked, 0);
    check("loss_err_count", err_seen, 2);

    // Reset mid-payload at bit 4 of a locked frame
    step(0, 0, 1, "rm");
    repeat (2) begin send_word(SW, 4, 0, "rm"); send_word(32'hA5, 8, 0, "rm"); end
    send_word(SW, 4, 0, "rm");
    send_word(32'hA5, 4, 0, "rm");
    pv_seen = 0;
    step(0, 1, 1, "rm");
    check("rm_state", sync_state, 0);
    check("rm_locked", locked, 0);
    check("rm_payload", payload, 0);
    check("rm_pvalid", payload_valid, 0);
    check("rm_serr", sync_error, 0);
`ifdef FRAME_SYNC_STATS_EN
    check("rm_frames", frame_count, 0);
    check("rm_losses", loss_count, 0);
`endif
    send_word(32'h0A, 4, 0, "rm");
    check("rm_no_partial", pv_seen, 0);

    // Random gapped stream with occasional bad syncs and slips
    step(0, 0, 1, "rnd");
    pv_seen = 0; m_pv_total = 0;
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 99) < 6) send_word($urandom, $urandom_range(1, 5), 1, "rnd");
      w = 32'(SW);
      if ($urandom_range(0, 99) < 15) w[$urandom_range(0, SL - 1)] ^= 1'b1;
      send_word(w, SL, 1, "rnd");
      send_word($urandom, PL, 1, "rnd");
    end
    check("rnd_pv_total", pv_seen, m_pv_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
